// File: rtl/framer_pkg.sv
// Shared constants and types for the sample framer: message field layout,
// FIFO payload format and send-FSM state codes.
package framer_pkg;

  localparam int PAYLOAD_W = 40;
  localparam int SEQ_LSB   = 56;
  localparam int DATA_LSB  = 40;
  localparam int TS_LSB    = 24;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  // One queued sample: sequence number, sample value, timestamp.
  typedef struct packed {
    logic [7:0]  seq;
    logic [15:0] data;
    logic [15:0] ts;
  } entry_t;

endpackage

// File: rtl/sample_framer_if.sv
// Request/grant message handshake between a framer and one arbitrator slot.
interface sample_framer_if;
  logic        u_req;
  logic        u_ack;
  logic [63:0] u_msg;

  modport master (output u_req, output u_msg, input u_ack);
  modport slave  (input u_req, input u_msg, output u_ack);
endinterface

// File: rtl/framer_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers carry an extra wrap bit
// so full and empty are distinguishable; a push on full is accepted when a pop
// happens in the same cycle.
module framer_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr[AW-1:0]];
  assign level   = wptr - rptr;

  // Storage write; the slot written on a push-while-full is the one being read out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

  // Read/write pointer advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/sample_framer.sv
// Sample framer: timestamps and decimates 16-bit samples, queues them and
// offers each as a 64-bit message on a req/ack handshake.
module sample_framer
  import framer_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int TICK_DIV = 50
) (
  input  logic                   clk_50m,
  input  logic                   rst,
  input  logic                   en,
  input  logic [7:0]             decim,
  input  logic                   s_valid,
  input  logic [15:0]            s_data,
  sample_framer_if.master        bus,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             ovf_cnt
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]        pcnt;
  logic [15:0]          ts;
  logic [7:0]           dcnt;
  logic [7:0]           seq;
  logic [1:0]           state;
  logic                 req;
  logic [63:0]          msg, msg_next;
  logic                 full, empty, keep, pop, accept, drop;
  entry_t               din, head;
  logic [PAYLOAD_W-1:0] head_bits;

  assign keep   = en && s_valid && (dcnt == 8'd0);
  assign pop    = (state == S_IDLE) && !empty;
  assign accept = keep && (!full || pop);
  assign drop   = keep && full && !pop;
  assign din    = '{seq: seq, data: s_data, ts: ts};
  assign head   = head_bits;

  framer_fifo #(.DEPTH(DEPTH), .W(PAYLOAD_W)) u_fifo (
    .clk   (clk_50m),
    .rst   (rst),
    .push  (keep),
    .pop   (pop),
    .din   (din),
    .dout  (head_bits),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Free-running prescaler and timestamp, independent of en.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      pcnt <= '0;
      ts   <= '0;
    end else if (pcnt == PW'(TICK_DIV - 1)) begin
      pcnt <= '0;
      ts   <= ts + 16'd1;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // Decimation counter; disabling restarts the keep pattern.
  always_ff @(posedge clk_50m) begin
    if (rst || !en)   dcnt <= '0;
    else if (s_valid) dcnt <= (dcnt >= decim) ? 8'd0 : dcnt + 8'd1;
  end

  // Sequence number advances only on accepted pushes; drops count saturating.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      seq     <= '0;
      ovf_cnt <= '0;
    end else begin
      if (accept) seq <= seq + 8'd1;
      if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

  // Place the head entry into the message field layout.
  always_comb begin
    msg_next                   = '0;
    msg_next[SEQ_LSB +: 8]     = head.seq;
    msg_next[DATA_LSB +: 16]   = head.data;
    msg_next[TS_LSB +: 16]     = head.ts;
  end

  // Send FSM: pop into the message register, hold until granted, then wait
  // for the grant to drop so a multi-cycle ack cannot take a second message.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state <= S_IDLE;
      req   <= 1'b0;
      msg   <= '0;
    end else begin
      case (state)
        S_IDLE: if (!empty) begin
          msg   <= msg_next;
          req   <= 1'b1;
          state <= S_REQ;
        end
        S_REQ: if (bus.u_ack) begin
          req   <= 1'b0;
          state <= S_WAIT;
        end
        S_WAIT: if (!bus.u_ack) state <= S_IDLE;
        default: begin
          req   <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.u_req = req;
  assign bus.u_msg = msg;

endmodule

// File: tb/tb_sample_framer.sv
// Bench for sample_framer: a transaction-level model predicts the message
// stream from the keep/accept rules; a responder plays the arbitrator.
module tb_sample_framer;
  localparam int DEPTH = 8;
  localparam int TD    = 5;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0, s_valid = 1'b0;
  logic [7:0]    decim = 8'd0;
  logic [15:0]   s_data = 16'd0;
  logic [LW-1:0] level;
  logic [7:0]    ovf_cnt;

  sample_framer_if bus();

  sample_framer #(.DEPTH(DEPTH), .TICK_DIV(TD)) dut (
    .clk_50m (clk),
    .rst     (rst),
    .en      (en),
    .decim   (decim),
    .s_valid (s_valid),
    .s_data  (s_data),
    .bus     (bus),
    .level   (level),
    .ovf_cnt (ovf_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;

  // Edges since reset; read at a negedge it is the count before the next edge.
  int cyc;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Model state
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  int  seq_m, vidx, cap_left, ovf_m, proto_err;
  bit  auto_ack = 1'b0;

  task automatic model_clear();
    exp_q.delete(); got_q.delete();
    seq_m = 0; vidx = 0; ovf_m = 0; cap_left = -1; proto_err = 0;
  endtask

  // One clock of stimulus plus the model's prediction for it.
  task automatic tick(input bit e, input bit v, input logic [15:0] d, input logic [7:0] dm);
    logic [15:0] tsv;
    logic [7:0]  sq;
    @(negedge clk);
    en = e; s_valid = v; s_data = d; decim = dm;
    if (!e) vidx = 0;
    else if (v) begin
      if (vidx % (int'(dm) + 1) == 0) begin
        if (cap_left == 0) ovf_m = (ovf_m < 255) ? ovf_m + 1 : 255;
        else begin
          tsv = 16'((cyc / TD) % 65536);
          sq  = 8'(seq_m);
          exp_q.push_back({sq, d, tsv, 24'h000000});
          seq_m = (seq_m + 1) % 256;
          if (cap_left > 0) cap_left--;
        end
      end
      vidx++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; s_valid = 1'b0; auto_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic wait_msgs(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (got_q.size() >= n) begin ok = 1'b1; break; end
      @(posedge clk);
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  // Arbitrator model: after a random delay, hold ack for two cycles.
  int hold = 0, dly = 0;
  initial begin
    bus.u_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !auto_ack) begin
        bus.u_ack = 1'b0; hold = 0;
      end else if (hold > 0) begin
        bus.u_ack = 1'b1; hold--;
      end else begin
        bus.u_ack = 1'b0;
        if (bus.u_req) begin
          if (dly == 0) begin
            bus.u_ack = 1'b1; hold = 1; dly = $urandom_range(0, 2);
          end else dly--;
        end
      end
    end
  end

  // Message capture and protocol observation just after each edge.
  logic        req_q = 1'b0, ack_q = 1'b0;
  logic [63:0] msg_q = '0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        if (bus.u_ack && bus.u_req) proto_err++;
        if (bus.u_req && !req_q) begin
          if (bus.u_ack || ack_q) proto_err++;
          got_q.push_back(bus.u_msg);
        end
        if (bus.u_req && req_q && bus.u_msg !== msg_q) proto_err++;
      end
      req_q = bus.u_req; msg_q = bus.u_msg; ack_q = bus.u_ack;
    end
  end

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.u_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus.u_req); end
    n_cmp++; if (bus.u_msg !== 64'h0) begin n_fail++; $display("FAIL reset_msg: got %h want 0", bus.u_msg); end
    n_cmp++; if (level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_ovf: got %0d want 0", ovf_cnt); end
  endtask

  task automatic test_single();
    bit ok;
    auto_ack = 1'b1;
    tick(1, 1, 16'h1234, 8'd0);
    @(posedge clk); #1;
    n_cmp++; if (bus.u_req !== 1'b0) begin n_fail++; $display("FAIL single_req_n: got %b want 0", bus.u_req); end
    tick(1, 0, 16'h0, 8'd0);
    @(posedge clk); #1;
    n_cmp++; if (bus.u_req !== 1'b1) begin n_fail++; $display("FAIL single_req_n1: got %b want 1", bus.u_req); end
    n_cmp++; if (bus.u_msg !== exp_q[0]) begin n_fail++; $display("FAIL single_msg: got %h want %h", bus.u_msg, exp_q[0]); end
    n_cmp++; if (bus.u_msg[63:40] !== 24'h001234) begin n_fail++; $display("FAIL single_hdr: got %h want 001234", bus.u_msg[63:40]); end
    wait_msgs(1, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got %0d msgs want 1", got_q.size()); end
  endtask

  task automatic test_handshake();
    bit ok;
    tick(1, 1, 16'(($urandom)), 8'd0);
    tick(1, 0, 16'h0, 8'd0);
    wait_msgs(2, ok);
    n_cmp++; if (got_q.size() != 2) begin n_fail++; $display("FAIL hs_count: got %0d want 2", got_q.size()); end
    if (got_q.size() >= 2) begin
      n_cmp++; if (got_q[1][63:56] !== 8'h01) begin n_fail++; $display("FAIL hs_seq: got %h want 01", got_q[1][63:56]); end
      n_cmp++; if (got_q[1] !== exp_q[1]) begin n_fail++; $display("FAIL hs_msg: got %h want %h", got_q[1], exp_q[1]); end
    end
    n_cmp++; if (proto_err != 0) begin n_fail++; $display("FAIL hs_protocol: got %0d errors want 0", proto_err); end
  endtask

  task automatic test_decim();
    bit ok;
    do_reset();
    auto_ack = 1'b1;
    for (int i = 0; i < 12; i++) tick(1, 1, 16'(i), 8'd3);
    tick(1, 0, 16'h0, 8'd3);
    wait_msgs(3, ok);
    n_cmp++; if (got_q.size() != 3) begin n_fail++; $display("FAIL decim_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i][55:40] !== 16'(4 * i)) begin n_fail++; $display("FAIL decim_data%0d: got %h want %h", i, got_q[i][55:40], 16'(4 * i)); end
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL decim_msg%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    cap_left = DEPTH + 1;
    for (int i = 0; i < 12; i++) tick(1, 1, 16'($urandom), 8'd0);
    tick(1, 0, 16'h0, 8'd0);
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (level !== LW'(DEPTH)) begin n_fail++; $display("FAIL ovf_level: got %0d want %0d", level, DEPTH); end
    n_cmp++; if (ovf_cnt !== 8'(ovf_m)) begin n_fail++; $display("FAIL ovf_cnt: got %0d want %0d", ovf_cnt, ovf_m); end
    n_cmp++; if (bus.u_req !== 1'b1) begin n_fail++; $display("FAIL ovf_inflight: got %b want 1", bus.u_req); end
  endtask

  task automatic test_saturate();
    bit ok;
    for (int i = 0; i < 300; i++) tick(1, 1, 16'($urandom), 8'd0);
    tick(1, 0, 16'h0, 8'd0);
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (ovf_cnt !== 8'(ovf_m)) begin n_fail++; $display("FAIL sat_cnt: got %0d want %0d", ovf_cnt, ovf_m); end
    n_cmp++; if (ovf_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_255: got %0d want 255", ovf_cnt); end
    n_cmp++; if (level !== LW'(DEPTH)) begin n_fail++; $display("FAIL sat_level: got %0d want %0d", level, DEPTH); end
    @(negedge clk);
    cap_left = -1; auto_ack = 1'b1;
    wait_msgs(DEPTH + 1, ok);
    n_cmp++; if (got_q.size() != DEPTH + 1) begin n_fail++; $display("FAIL drain_count: got %0d want %0d", got_q.size(), DEPTH + 1); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i][63:56] !== 8'(i)) begin n_fail++; $display("FAIL drain_seq%0d: got %h want %h", i, got_q[i][63:56], 8'(i)); end
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL drain_msg%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    for (int i = 0; i < 5; i++) tick(1, 1, 16'($urandom), 8'd0);
    tick(1, 0, 16'h0, 8'd0);
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (bus.u_req !== 1'b1) begin n_fail++; $display("FAIL mid_req: got %b want 1", bus.u_req); end
    n_cmp++; if (level !== LW'(4)) begin n_fail++; $display("FAIL mid_level: got %0d want 4", level); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.u_req !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req: got %b want 0", bus.u_req); end
    n_cmp++; if (bus.u_msg !== 64'h0) begin n_fail++; $display("FAIL mid_rst_msg: got %h want 0", bus.u_msg); end
    n_cmp++; if (level !== '0) begin n_fail++; $display("FAIL mid_rst_level: got %0d want 0", level); end
    @(negedge clk); rst = 1'b0;
    model_clear();
    auto_ack = 1'b1;
    tick(1, 1, 16'hBEEF, 8'd0);
    tick(1, 0, 16'h0, 8'd0);
    wait_msgs(1, ok);
    n_cmp++; if (got_q.size() != 1) begin n_fail++; $display("FAIL mid_post_count: got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_cmp++; if (got_q[0][63:56] !== 8'h00) begin n_fail++; $display("FAIL mid_post_seq: got %h want 00", got_q[0][63:56]); end
      n_cmp++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL mid_post_msg: got %h want %h", got_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_random();
    bit ok, e, v;
    logic [7:0] dm;
    do_reset();
    auto_ack = 1'b1;
    dm = 8'd0;
    for (int i = 0; i < 1500; i++) begin
      e = ($urandom_range(0, 15) != 0);
      if (!e) dm = 8'($urandom_range(0, 3));
      v = ($urandom_range(0, 19) == 0);
      tick(e, v, 16'($urandom), dm);
    end
    tick(1, 0, 16'h0, dm);
    wait_msgs(exp_q.size(), ok);
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_msg%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (ovf_cnt !== 8'(ovf_m)) begin n_fail++; $display("FAIL rnd_ovf: got %0d want %0d", ovf_cnt, ovf_m); end
    n_cmp++; if (proto_err != 0) begin n_fail++; $display("FAIL rnd_protocol: got %0d errors want 0", proto_err); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_handshake();
    test_decim();
    test_overflow();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/sample_framer.md
# sample_framer

Upstream producer for one channel of the UART arbitrator. It accepts 16-bit measurement samples, decimates them and timestamps them, and queues them in a small FIFO. It then presents each one as a 64-bit message on the arbitrator's `u_req`/`u_ack`/`uN_msg` handshake. One instance drives one arbitrator request slot; the arbitrator fills bits [23:0] with the channel byte and the 0x5AA5 sync header itself.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `TICK_DIV`, 50: `clk_50m` cycles per timestamp tick (50 gives 1 µs).
- `clk_50m`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `en`  in  1  sample acceptance enable.
- `decim`  in  8  keep 1 of every `decim`+1 valid samples; sampled live.
- `s_valid`  in  1  single-cycle sample strobe.
- `s_data`  in  16  sample value, valid with `s_valid`.
- `u_req`  out  1  message request to arbitrator.
- `u_ack`  in  1  arbitrator grant.
- `u_msg`  out  64  message; stable while `u_req`=1.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `ovf_cnt`  out  8  dropped-sample count, saturating.

## Operation
- Timestamp `ts[15:0]`:
  - A prescaler counts 0..`TICK_DIV`-1.
  - `ts` increments when the prescaler wraps, modulo 2^16.
  - It runs regardless of `en`.
- Decimation:
  - `dcnt[7:0]` counts valid samples while `en`=1.
  - A sample is kept when `dcnt`==0.
  - `dcnt` reloads to 0 after reaching ≥`decim`, so `decim`=0 keeps every sample.
  - `en`=0 forces `dcnt` to 0 and drops all samples. These drops do not count in `ovf_cnt`.
- Enqueue:
  - A kept sample pushes the entry {`seq[7:0]`, `s_data`, `ts`} (40 bits).
  - `seq` increments by 1 per push, wrapping 255→0.
  - If the FIFO is full and there is no pop in the same cycle, the sample is dropped, `ovf_cnt` increments (saturating at 255) and `seq` is unchanged.
  - A push on full is accepted if a pop occurs in the same cycle.
- Message format: `u_msg` = {entry[39:0], 24'h000000}, i.e. [63:56] seq, [55:40] sample, [39:24] ts. Bits [23:0] are zero.
- Send FSM:
  - `S_IDLE`: when the FIFO is not empty, pop the head into the `u_msg` register, set `u_req`=1 and go to `S_REQ`.
  - `S_REQ`: hold `u_req` and `u_msg`. On `u_ack`=1, clear `u_req` and go to `S_WAIT`.
  - `S_WAIT`: stay until `u_ack`=0, then go to `S_IDLE`. This prevents a second grant of the same message, because the arbitrator holds ack for 2 cycles.
  - Any other state code returns to `S_IDLE` with `u_req`=0.
- `en` does not affect draining; queued entries are still sent.
- Reset values:
  - `u_req`=0, `u_msg`=0, `level`=0, `ovf_cnt`=0.
  - FIFO pointers=0, `seq`=0, `ts`=0, prescaler=0, `dcnt`=0, state `S_IDLE`.
  - Reset mid-handshake drops the in-flight message and all queued entries.

## Timing
- Kept `s_valid` at edge N: entry written at N. It is visible to the FSM in cycle N+1. `u_req`=1 with `u_msg` valid after edge N+1, a latency of 2 cycles to an empty, idle framer.
- The `ts` captured is the value in cycle N, before any tick at edge N.
- `u_ack` first high at edge A: `u_req`=0 after edge A. `S_WAIT` until ack is sampled low. The next `u_req` rises no earlier than 2 cycles after ack falls.
- The pop and the `level` decrement happen at the `S_IDLE`→`S_REQ` edge, so the in-flight message does not count in `level`.
- Simultaneous push and pop leaves `level` unchanged.
- All outputs are registered; there is no combinational path from an input to an output.

## Structure
- Shared package `framer_pkg`:
  - Field offsets: `SEQ_LSB`=56, `DATA_LSB`=40, `TS_LSB`=24.
  - Payload width constant (40).
  - FSM state encoding.
- Sub-module `framer_fifo`: a synchronous, first-word-fall-through FIFO with parameters `DEPTH` and `W`=40. Ports: push, pop, din, dout, full, empty, level. Pointers carry one extra bit for wrap.
- Top: prescaler, timestamp, decimation, seq/ovf counters and the send FSM.

## Test plan
- Reset, then one sample 0x1234 with `decim`=0 and `en`=1 → `u_req` high 2 cycles later. `u_msg`[63:24]=0x00_1234_tttt with `ts` matching; bits [23:0]=0.
- Hold `u_ack` high for 2 cycles, model the arbitrator → exactly one message is consumed. `u_req` stays low until ack drops; the next message has seq=0x01.
- `decim`=3, 12 consecutive strobes → 3 messages, carrying samples 0, 4 and 8.
- `DEPTH`=8, hold `u_ack`=0, 12 samples → `level`=8 (plus 1 in flight). `ovf_cnt`=3. After draining, seq values are contiguous 0..8.
- `u_ack` never asserted, 300 samples into a full FIFO → `ovf_cnt` saturates at 255.
- Assert `rst` while `u_req`=1 with 4 entries queued → the next cycle shows `u_req`=0, `u_msg`=0 and `level`=0. After release, the first new message has seq=0x00.
